// File: rtl/sb_drain_ctrl.sv
// Store-buffer drain controller: pops buffered dirty entries one at a time and writes them to
// memory, sharing the memory port with the cache refill path through a small priority arbiter.
module sb_drain_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PTR_W  = 6,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sb_empty_i,
  input  logic              sb_full_i,
  input  logic [ADDR_W-1:0] sb_raddr_i,
  input  logic [DATA_W-1:0] sb_rdata_i,
  output logic              sb_re_o,
  output logic [PTR_W-1:0]  read_ptr_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic              refill_req_i,
  output logic              refill_gnt_o,
  input  logic              drain_all_i,
  output logic              drain_busy_o,
  output logic              drained_o,
  output logic [CNT_W-1:0]  wr_count_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StWrite, StGrant} state_e;

  state_e             state_q;
  logic [PTR_W-1:0]   read_ptr_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic [CNT_W-1:0]   wr_count_q;
  logic               sb_re_q;
  logic               mem_req_q;
  logic               refill_gnt_q;

  // Strobes are registered alongside the state so each one is high exactly while in its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      read_ptr_q   <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wr_count_q   <= '0;
      sb_re_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      refill_gnt_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A full buffer or a forced drain outranks the refill path; otherwise refill goes first.
          if (!sb_empty_i && (sb_full_i || drain_all_i)) begin
            state_q <= StFetch;
            sb_re_q <= 1'b1;
          end else if (refill_req_i) begin
            state_q      <= StGrant;
            refill_gnt_q <= 1'b1;
          end else if (!sb_empty_i) begin
            state_q <= StFetch;
            sb_re_q <= 1'b1;
          end
        end
        StFetch: begin
          mem_addr_q  <= sb_raddr_i;
          mem_wdata_q <= sb_rdata_i;
          sb_re_q     <= 1'b0;
          mem_req_q   <= 1'b1;
          state_q     <= StWrite;
        end
        StWrite: begin
          if (mem_ack_i) begin
            read_ptr_q <= read_ptr_q + PTR_W'(1);
            if (wr_count_q != {CNT_W{1'b1}}) begin
              wr_count_q <= wr_count_q + CNT_W'(1);
            end
            mem_req_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        StGrant: begin
          if (!refill_req_i) begin
            refill_gnt_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: begin
          state_q      <= StIdle;
          sb_re_q      <= 1'b0;
          mem_req_q    <= 1'b0;
          refill_gnt_q <= 1'b0;
        end
      endcase
    end
  end

  assign sb_re_o      = sb_re_q;
  assign read_ptr_o   = read_ptr_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign refill_gnt_o = refill_gnt_q;
  assign wr_count_o   = wr_count_q;
  assign drain_busy_o = (state_q == StFetch) || (state_q == StWrite);
  assign drained_o    = sb_empty_i && (state_q == StIdle);

endmodule
